// File: rtl/vga_board_capture.sv
// Receive side of the Game-of-Life VGA link: recovers raster position from the syncs, locks to
// the nominal timing and reads the 8x8 cell board back from the cell-centre pixels.
module vga_board_capture #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned BOARD_BITS = 3,
  parameter int unsigned CELL_SIZE  = 50,
  parameter int unsigned ORIGIN_X   = 120,
  parameter int unsigned ORIGIN_Y   = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        locked,
  output logic [63:0] board,
  output logic        board_valid,
  output logic        colour_err,
  output logic        timing_err
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_POS  = H_VISIBLE + H_FRONT;
  localparam int unsigned VS_POS  = V_VISIBLE + V_FRONT;
  localparam int unsigned CX0     = ORIGIN_X + CELL_SIZE / 2;
  localparam int unsigned CY0     = ORIGIN_Y + CELL_SIZE / 2;
  localparam int unsigned N_CELLS = 1 << (2 * BOARD_BITS);
  localparam int unsigned CNT_W   = 2 * BOARD_BITS + 1;
  localparam logic [BOARD_BITS:0] STEP_ONE = 1;

  typedef enum logic [2:0] {StSearch, StHcheck, StVsearch, StVcheck, StLocked} state_e;

  state_e state_q, state_d;

  logic [7:0]              vga_q;
  logic                    hs_prev_q, vs_prev_q;
  logic [9:0]              hpos_q, vpos_q, hpos_d, vpos_d, h_cur, v_cur;
  logic                    vs_seen_q;
  logic [9:0]              cx_q, cy_q;
  logic [BOARD_BITS:0]     col_q, row_q;
  logic [63:0]             shadow_q, board_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    flag_q, frame_ok_q, board_valid_q, colour_err_q;

  logic hs_fall, vs_fall, hs_at, vs_at, line_end, frame_start;
  logic hs_err, vs_err, lock_err, x_hit, y_hit, sample, commit;
  logic pix_alive, pix_dead;

  assign hs_fall     = ~vga_q[7] & hs_prev_q;
  assign vs_fall     = ~vga_q[3] & vs_prev_q;
  assign hs_at       = hpos_q == 10'(HS_POS);
  assign vs_at       = vpos_q == 10'(VS_POS);
  assign line_end    = hpos_q == 10'(H_TOTAL - 1);
  assign frame_start = (hpos_q == 10'd0) && (vpos_q == 10'd0);

  // An hsync error is a fall off position or a missing fall at position.
  assign hs_err   = hs_fall ^ hs_at;
  assign vs_err   = (vs_fall & ~vs_at) | (vs_at & line_end & ~(vs_seen_q | vs_fall));
  assign lock_err = hs_err | vs_err;

  // R, G, B pairs are split across the two nibbles of the pin bus.
  assign pix_alive = ({vga_q[0], vga_q[4]} == 2'b10) && ({vga_q[1], vga_q[5]} == 2'b00) &&
                     ({vga_q[2], vga_q[6]} == 2'b10);
  assign pix_dead  = ({vga_q[0], vga_q[4]} == 2'b11) && ({vga_q[1], vga_q[5]} == 2'b10) &&
                     ({vga_q[2], vga_q[6]} == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StSearch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StSearch:  if (hs_fall) state_d = StHcheck;
      StHcheck:  if (hs_err) state_d = StSearch;
                 else if (hs_fall) state_d = StVsearch;
      StVsearch: if (hs_err) state_d = StSearch;
                 else if (vs_fall) state_d = StVcheck;
      StVcheck:  if (hs_err || (vs_fall && !vs_at)) state_d = StSearch;
                 else if (vs_fall) state_d = StLocked;
      StLocked:  if (lock_err) state_d = StSearch;
      default:   state_d = StSearch;
    endcase
  end

  always_comb begin
    locked     = state_q == StLocked;
    timing_err = locked & lock_err;
    x_hit      = (hpos_q == cx_q) && !col_q[BOARD_BITS];
    y_hit      = (vpos_q == cy_q) && !row_q[BOARD_BITS];
    sample     = locked & frame_ok_q & x_hit & y_hit;
    commit     = locked & frame_ok_q & (hpos_q == 10'd0) & (vpos_q == 10'(V_VISIBLE)) &
                 (cnt_q == CNT_W'(N_CELLS));
  end

  // A sync fall while searching defines the position of the pixel currently in vga_q.
  always_comb begin
    h_cur  = (state_q == StSearch && hs_fall) ? 10'(HS_POS) : hpos_q;
    v_cur  = (state_q == StVsearch && vs_fall) ? 10'(VS_POS) : vpos_q;
    hpos_d = (h_cur == 10'(H_TOTAL - 1)) ? 10'd0 : h_cur + 10'd1;
    vpos_d = v_cur;
    if (h_cur == 10'(H_TOTAL - 1)) vpos_d = (v_cur == 10'(V_TOTAL - 1)) ? 10'd0 : v_cur + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_q         <= '0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      vs_seen_q     <= 1'b0;
      cx_q          <= '0;
      cy_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      shadow_q      <= '0;
      cnt_q         <= '0;
      flag_q        <= 1'b0;
      frame_ok_q    <= 1'b0;
      board_q       <= '0;
      board_valid_q <= 1'b0;
      colour_err_q  <= 1'b0;
    end else begin
      vga_q     <= vga_in;
      hs_prev_q <= vga_q[7];
      vs_prev_q <= vga_q[3];
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      vs_seen_q <= line_end ? 1'b0 : (vs_seen_q | (vs_fall & vs_at));

      // Stepped centre trackers: columns restart every line, rows every frame.
      if (line_end) begin
        cx_q  <= 10'(CX0);
        col_q <= '0;
      end else if (x_hit) begin
        cx_q  <= cx_q + 10'(CELL_SIZE);
        col_q <= col_q + STEP_ONE;
      end
      if (frame_start) begin
        cy_q  <= 10'(CY0);
        row_q <= '0;
      end else if (line_end && y_hit) begin
        cy_q  <= cy_q + 10'(CELL_SIZE);
        row_q <= row_q + STEP_ONE;
      end

      if (!locked)          frame_ok_q <= 1'b0;
      else if (frame_start) frame_ok_q <= 1'b1;

      if (locked && frame_start) begin
        shadow_q <= '0;
        cnt_q    <= '0;
        flag_q   <= 1'b0;
      end else if (sample) begin
        shadow_q[{row_q[BOARD_BITS-1:0], col_q[BOARD_BITS-1:0]}] <= pix_alive;
        cnt_q  <= cnt_q + CNT_W'(1);
        flag_q <= flag_q | ~(pix_alive | pix_dead);
      end

      board_valid_q <= commit;
      if (commit) begin
        board_q      <= shadow_q;
        colour_err_q <= flag_q;
      end
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign board       = board_q;
  assign board_valid = board_valid_q;
  assign colour_err  = colour_err_q;

endmodule
